// File: rtl/uart_rx_16x_if.sv
// FIFO write port of the 16x UART receiver: a 9-bit word with its write strobe,
// plus the back-pressure flag coming from the FIFO.
interface uart_rx_16x_if #(parameter int DATA_BITS = 8);
  // Handshake: wrEn is a one-clock write strobe. dataOut is valid in that clock
  // and held until the next write. The receiver raises wrEn only if fifoFull was
  // low when the stop bit was sampled. There is no retry: a refused frame is
  // dropped and reported on overrun.
  logic [DATA_BITS:0] dataOut;
  logic               wrEn;
  logic               fifoFull;

  modport master (output dataOut, output wrEn, input fifoFull);
  modport slave  (input dataOut, input wrEn, output fifoFull);
endinterface

// File: rtl/uart_rx_16x.sv
// 16x-oversampled UART receiver: start + DATA_BITS (LSB first) + even parity + 1 stop.
// Good-stop frames are written as {parErr, data} into the RX FIFO.
module uart_rx_16x #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLK288MHZ,
  input  logic            reset,
  input  logic            tick,
  input  logic            rxd,
  uart_rx_16x_if.master   fifo,
  output logic            frameErr,
  output logic            overrun,
  output logic            busy,
  output logic [2:0]      state_dbg
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rxs;
  logic [TW-1:0]        tick_cnt, tick_cnt_d;
  logic [BW-1:0]        bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par_err, par_err_d;
  logic                 armed, armed_d;
  logic [DATA_BITS:0]   data_q, data_d;
  logic                 wr_q, wr_d;
  logic                 ferr_d, ovr_d;

  assign rxs          = sync_q[SYNC_STAGES-1];
  assign busy         = (state != IDLE);
  assign state_dbg    = state;
  assign fifo.dataOut = data_q;
  assign fifo.wrEn    = wr_q;

  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    par_err_d  = par_err;
    armed_d    = armed;
    data_d     = data_q;
    wr_d       = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = overrun;
    case (state)
      // armed stays low after a framing error until the line returns high,
      // so a line held low cannot start a stream of bogus frames.
      IDLE: begin
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == MID_TICK) begin
            if (!rxs) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == LAST_TICK) begin
            shreg_d    = {rxs, shreg[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt + BW'(1);
            tick_cnt_d = '0;
            if (bit_cnt == LAST_BIT) state_d = PARITY;
          end else begin
            tick_cnt_d = tick_cnt + TW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (tick_cnt == LAST_TICK) begin
            par_err_d  = rxs ^ (^shreg);
            tick_cnt_d = '0;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt + TW'(1);
          end
        end
      end
      // Leaving mid stop bit gives half a bit of slack to catch the next start edge.
      STOP: begin
        if (tick) begin
          if (tick_cnt == LAST_TICK) begin
            state_d = IDLE;
            if (!rxs) begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end else if (fifo.fifoFull) begin
              ovr_d = 1'b1;
            end else begin
              wr_d   = 1'b1;
              data_d = {par_err, shreg};
            end
          end else begin
            tick_cnt_d = tick_cnt + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK288MHZ) begin
    if (reset) begin
      state    <= IDLE;
      sync_q   <= '1;
      armed    <= 1'b1;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
      armed    <= armed_d;
      tick_cnt <= tick_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      par_err  <= par_err_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      frameErr <= ferr_d;
      overrun  <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: table of whole frames plus hand-written
// sequences for glitch, held-low line, back-to-back frames and mid-frame reset.
module tb_uart_rx_16x;

  localparam int BIT_CLKS = 48;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       rxd;
  logic       frameErr;
  logic       overrun;
  logic       busy;
  logic [2:0] state_dbg;

  uart_rx_16x_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_16x dut (
    .CLK288MHZ (clk),
    .reset     (reset),
    .tick      (tick),
    .rxd       (rxd),
    .fifo      (rx_if.master),
    .frameErr  (frameErr),
    .overrun   (overrun),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset / tick
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int div;
    div  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (div == 2);
      div  = (div == 2) ? 0 : div + 1;
    end
  end

  // scoreboard
  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int ferr_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_if.wrEn) begin
      got_q.push_back(rx_if.dataOut);
      wr_cnt++;
    end
    if (frameErr) ferr_cnt++;
    if (rx_if.wrEn || frameErr) check("wr_ferr_exclusive", 32'(rx_if.wrEn & frameErr), 32'd0);
  end

  task automatic compare_words();
    logic [8:0] e;
    logic [8:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check("word_missing", 32'd0, 32'(e));
      end else begin
        g = got_q.pop_front();
        check("word", 32'(g), 32'(e));
      end
    end
    check("no_extra_words", 32'(got_q.size()), 32'd0);
    got_q.delete();
  endtask

  // driver tasks
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stp;
    logic       full;
    logic       exp_wr;
    logic [8:0] exp_word;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w0;
    int f0;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 9'h0A5, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 9'h101, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 9'h080, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 9'h1FF, 1'b0};
    vecs[4] = '{8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b1};
    vecs[5] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 9'h03C, 1'b1};

    reset          = 1'b1;
    rxd            = 1'b1;
    rx_if.fifoFull = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_dataOut",  32'(rx_if.dataOut), 32'd0);
    check("rst_wrEn",     32'(rx_if.wrEn),    32'd0);
    check("rst_frameErr", 32'(frameErr),      32'd0);
    check("rst_overrun",  32'(overrun),       32'd0);
    check("rst_busy",     32'(busy),          32'd0);
    check("rst_state",    32'(state_dbg),     32'd0);
    reset = 1'b0;
    idle(20);

    // glitch: low for 4 ticks only
    w0 = wr_cnt; f0 = ferr_cnt;
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    check("glitch_busy_start", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);
    idle(34);
    check("glitch_idle",  32'(busy),           32'd0);
    check("glitch_wr",    32'(wr_cnt - w0),    32'd0);
    check("glitch_ferr",  32'(ferr_cnt - f0),  32'd0);
    idle(40);

    // framing error, line held low, then a clean frame
    w0 = wr_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (60) @(negedge clk);
    check("held_low_idle", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    check("ferr_once",     32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_wr",    32'(wr_cnt - w0),   32'd0);
    check("held_low_busy", 32'(busy),          32'd0);
    idle(60);
    w0 = wr_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    idle(60);
    exp_q.push_back(9'h055);
    check("after_ferr_wr",   32'(wr_cnt - w0),   32'd1);
    check("after_ferr_ferr", 32'(ferr_cnt - f0), 32'd0);
    compare_words();

    // table of whole frames
    for (int i = 0; i < 6; i++) begin
      w0 = wr_cnt; f0 = ferr_cnt;
      rx_if.fifoFull = vecs[i].full;
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stp);
      idle(60);
      rx_if.fifoFull = 1'b0;
      if (vecs[i].exp_wr) exp_q.push_back(vecs[i].exp_word);
      check($sformatf("vec%0d_wr", i),   32'(wr_cnt - w0),   32'(vecs[i].exp_wr));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'd0);
      check($sformatf("vec%0d_ovr", i),  32'(overrun),       32'(vecs[i].exp_ovr));
      check($sformatf("vec%0d_busy", i), 32'(busy),          32'd0);
      compare_words();
    end

    // back-to-back frames with no idle between them
    w0 = wr_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(60);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h0FF);
    check("b2b_wr", 32'(wr_cnt - w0), 32'd2);
    compare_words();

    // reset in the middle of a frame
    w0 = wr_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("midframe_state", 32'(state_dbg), 32'd2);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy",    32'(busy),    32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    idle(100);
    check("midrst_no_wr", 32'(wr_cnt - w0), 32'd0);
    w0 = wr_cnt;
    send_frame(8'h81, 1'b0, 1'b1);
    idle(60);
    exp_q.push_back(9'h081);
    check("post_rst_wr", 32'(wr_cnt - w0), 32'd1);
    compare_words();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
